bsg_wormhole_packet_serializer: RTL and testbench
=================================================

Name: bsg_wormhole_packet_serializer

Overview:
- Upstream feeder stage for the wormhole concentrator.
- Accepts one complete packet per handshake from a node-side client: destination cord, destination cid, payload length and up to max_payload_flits_p payload flits.
- Emits the packet as a header flit followed by len payload flits on a ready-and link.
- The output connects directly to one unconcentrated input of the concentrator (or to a router P port).

Parameters:
- flit_width_p, 32, link flit width in bits.
- cord_width_p, 8, destination coordinate field width.
- len_width_p, 4, length field width; counts flits following the header.
- cid_width_p, 2, concentration id field width.
- max_payload_flits_p, 4, maximum payload flits per packet; must be <= 2**len_width_p-1.
- hdr_data_width_p, flit_width_p-cord_width_p-len_width_p-cid_width_p, spare header bits carried from the client.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- pkt_v_i  in  1  packet valid.
- pkt_ready_o  out  1  packet accept.
- pkt_cord_i  in  cord_width_p  destination cord.
- pkt_cid_i  in  cid_width_p  destination cid.
- pkt_len_i  in  len_width_p  number of payload flits.
- pkt_hdr_data_i  in  hdr_data_width_p  spare header payload.
- pkt_data_i  in  max_payload_flits_p*flit_width_p  payload; flit 0 in the LSBs.
- v_o  out  1  flit valid.
- data_o  out  flit_width_p  flit.
- ready_and_i  in  1  downstream ready.
- packets_sent_o  out  32  count of packets whose last flit has handshaken.

Behaviour:
- Header flit layout, LSB first: cord [cord_width_p-1:0], then len, then cid, then hdr_data. The concentrator decodes cid at bit offset cord_width_p+len_width_p.
- States:
  - IDLE: v_o=0, pkt_ready_o=1.
  - HDR: v_o=1, data_o=header.
  - BODY: v_o=1, data_o=payload flit indexed by a flit counter.
- Transitions:
  - IDLE --pkt_v_i--> HDR, latching all packet fields into registers.
  - HDR --ready_and_i & len!=0--> BODY, counter=0.
  - HDR --ready_and_i & len==0--> IDLE, or HDR if re-accepting.
  - BODY --ready_and_i & counter==len-1--> IDLE, or HDR if re-accepting; otherwise counter++ on each ready_and_i.
- Back-to-back: pkt_ready_o = IDLE | (last flit & ready_and_i). Last flit is HDR with len==0, or BODY with counter==len-1. A packet accepted on the last-flit cycle presents its header the next cycle, so there are no bubbles between packets.
- Latency: header is valid on the cycle after acceptance. Outputs are fully registered and there is no combinational path from pkt_* to data_o/v_o. pkt_ready_o depends combinationally on ready_and_i only.
- Valid/ready rules:
  - v_o never depends on ready_and_i.
  - Once v_o=1, data_o holds stable until ready_and_i.
  - Input registers change only on pkt_v_i & pkt_ready_o.
- pkt_len_i > max_payload_flits_p is illegal: a simulation assertion fires, and RTL clamps both the header len field and the flit count to max_payload_flits_p.
- packets_sent_o increments by 1 on each last-flit handshake and wraps at 2**32.
- Reset (asynchronous, active-high; applies to all outputs and flops, including mid-packet): state=IDLE, v_o=0, data_o=0, counter=0, packets_sent_o=0, pkt_ready_o=0 while reset_i is high. Any partial packet is dropped; no resume.

Decomposition:
- Header field packing is a struct macro in bsg_noc_links.vh / shared wormhole package: declare_bsg_wormhole_concentrator_header_s(cord, len, cid, hdr_data). The concentrator and the test nodes use the same macro.
- State enum stays local to the module.
- One sub-module: bsg_wormhole_packet_serializer_ctr, the flit index counter with clear/up and last-flit compare.

Test Plan:
- Single packet, cord=7, cid=2, len=3, data flits 0xA0..0xA2, ready_and_i tied 1 -> header accepted cycle+1. Flits on data_o: {hdr: cord=7, len=3, cid=2}, 0xA0, 0xA1, 0xA2 on consecutive cycles; packets_sent_o=1.
- Header-only packet len=0 -> exactly one flit, v_o drops the next cycle, pkt_ready_o=1 in the same cycle as the handshake.
- Back-to-back: 5 packets of len=2 with pkt_v_i held high -> 15 consecutive valid flits with no bubbles; packets_sent_o=5.
- Random ready_and_i backpressure (50%) over 100 packets with random len 0..4 -> data_o stable while v_o & ~ready_and_i; the scoreboard matches every flit; packets_sent_o=100.
- Illegal len=9 with max=4 -> assertion fires; header len field=4; 4 payload flits are sent.
- Reset asserted mid-BODY (after the 2nd of 4 flits) -> v_o=0 and packets_sent_o=0 immediately, without a clock edge. After release, the next packet starts cleanly with its header.

Source files
------------

// File: rtl/bsg_wormhole_packet_serializer_pkg.sv
// Shared defaults for the wormhole packet serializer and its length clamp helper.
package bsg_wormhole_packet_serializer_pkg;

    localparam int unsigned flit_width_def_lp        = 32;
    localparam int unsigned cord_width_def_lp        = 8;
    localparam int unsigned len_width_def_lp         = 4;
    localparam int unsigned cid_width_def_lp         = 2;
    localparam int unsigned max_payload_flits_def_lp = 4;

    // Out-of-range lengths are clamped so header len and flit count always agree.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/bsg_wormhole_packet_serializer_ctr.sv
// Payload flit index counter: clear/up control with a compare against the last index.
module bsg_wormhole_packet_serializer_ctr #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    input  logic [width_p-1:0] last_idx_i,
    output logic [width_p-1:0] count_o,
    output logic               last_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (up_i) begin
            count_o <= count_o + 1'b1;
        end
    end

    assign last_o = (count_o == last_idx_i);

endmodule

// File: rtl/bsg_wormhole_packet_serializer.sv
// Serializes one whole client packet into a header flit plus len payload flits
// on a ready-and link, with back-to-back acceptance on the last flit.
//
// state  | meaning
// e_idle | no packet held, ready for a new one
// e_hdr  | presenting the header flit
// e_body | presenting payload flit [counter]
module bsg_wormhole_packet_serializer
    import bsg_wormhole_packet_serializer_pkg::*;
#(
    parameter int flit_width_p        = flit_width_def_lp,
    parameter int cord_width_p        = cord_width_def_lp,
    parameter int len_width_p         = len_width_def_lp,
    parameter int cid_width_p         = cid_width_def_lp,
    parameter int max_payload_flits_p = max_payload_flits_def_lp,
    parameter int hdr_data_width_p    = flit_width_p - cord_width_p - len_width_p - cid_width_p
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        pkt_v_i,
    output logic                                        pkt_ready_o,
    input  logic [cord_width_p-1:0]                     pkt_cord_i,
    input  logic [cid_width_p-1:0]                      pkt_cid_i,
    input  logic [len_width_p-1:0]                      pkt_len_i,
    input  logic [hdr_data_width_p-1:0]                 pkt_hdr_data_i,
    input  logic [max_payload_flits_p*flit_width_p-1:0] pkt_data_i,
    output logic                                        v_o,
    output logic [flit_width_p-1:0]                     data_o,
    input  logic                                        ready_and_i,
    output logic [31:0]                                 packets_sent_o
);

    localparam int idx_width_lp = (max_payload_flits_p > 1) ? $clog2(max_payload_flits_p) : 1;

    // Same field order the concentrator decodes: cid sits at cord_width_p+len_width_p.
    typedef struct packed {
        logic [hdr_data_width_p-1:0] hdr_data;
        logic [cid_width_p-1:0]      cid;
        logic [len_width_p-1:0]      len;
        logic [cord_width_p-1:0]     cord;
    } header_s;

    typedef enum logic [1:0] {e_idle, e_hdr, e_body} state_e;

    state_e                  state_r, state_n;
    header_s                 hdr_r;
    logic [flit_width_p-1:0] payload_r [max_payload_flits_p];
    logic [len_width_p-1:0]  len_clamped;
    logic [len_width_p-1:0]  ctr_count;
    logic                    ctr_last;
    logic                    last_flit;
    logic                    accept;

    assign len_clamped = len_width_p'(clamp_len(32'(pkt_len_i), max_payload_flits_p));
    assign last_flit   = ((state_r == e_hdr) && (hdr_r.len == '0))
                       || ((state_r == e_body) && ctr_last);
    assign pkt_ready_o = !reset_i && ((state_r == e_idle) || (last_flit && ready_and_i));
    assign accept      = pkt_v_i && pkt_ready_o;
    assign v_o         = (state_r != e_idle);

    bsg_wormhole_packet_serializer_ctr #(
        .width_p(len_width_p)
    ) ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (state_r != e_body),
        .up_i      ((state_r == e_body) && ready_and_i),
        .last_idx_i(hdr_r.len - 1'b1),
        .count_o   (ctr_count),
        .last_o    (ctr_last)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r        <= e_idle;
            hdr_r          <= '0;
            packets_sent_o <= '0;
            for (int i = 0; i < max_payload_flits_p; i++) payload_r[i] <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                hdr_r <= '{hdr_data: pkt_hdr_data_i, cid: pkt_cid_i, len: len_clamped, cord: pkt_cord_i};
                for (int i = 0; i < max_payload_flits_p; i++)
                    payload_r[i] <= pkt_data_i[i*flit_width_p +: flit_width_p];
            end
            if (last_flit && ready_and_i) packets_sent_o <= packets_sent_o + 32'd1;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle: if (pkt_v_i) state_n = e_hdr;
            e_hdr: begin
                if (ready_and_i) begin
                    if (hdr_r.len != '0) state_n = e_body;
                    else                 state_n = pkt_v_i ? e_hdr : e_idle;
                end
            end
            e_body: if (ready_and_i && ctr_last) state_n = pkt_v_i ? e_hdr : e_idle;
            default: state_n = e_idle;
        endcase
    end

    always_comb begin
        data_o = '0;
        unique case (state_r)
            e_hdr:   data_o = hdr_r;
            e_body:  data_o = payload_r[ctr_count[idx_width_lp-1:0]];
            default: data_o = '0;
        endcase
    end

    always @(posedge clk_i) begin
        if (!reset_i && accept)
            assert (pkt_len_i <= len_width_p'(max_payload_flits_p))
            else $warning("serializer: pkt_len_i %0d above max_payload_flits_p, clamping", pkt_len_i);
    end

endmodule

// File: tb/tb_bsg_wormhole_packet_serializer.sv
// Directed plus randomized bench; expected flits come from a packet-level queue model.
module tb_bsg_wormhole_packet_serializer;

    logic         clk;
    logic         reset_i;
    logic         pkt_v_i;
    logic         pkt_ready_o;
    logic [7:0]   pkt_cord_i;
    logic [1:0]   pkt_cid_i;
    logic [3:0]   pkt_len_i;
    logic [17:0]  pkt_hdr_data_i;
    logic [127:0] pkt_data_i;
    logic         v_o;
    logic [31:0]  data_o;
    logic         ready_and_i;
    logic [31:0]  packets_sent_o;

    bsg_wormhole_packet_serializer dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .pkt_v_i       (pkt_v_i),
        .pkt_ready_o   (pkt_ready_o),
        .pkt_cord_i    (pkt_cord_i),
        .pkt_cid_i     (pkt_cid_i),
        .pkt_len_i     (pkt_len_i),
        .pkt_hdr_data_i(pkt_hdr_data_i),
        .pkt_data_i    (pkt_data_i),
        .v_o           (v_o),
        .data_o        (data_o),
        .ready_and_i   (ready_and_i),
        .packets_sent_o(packets_sent_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } flit_t;

    flit_t       q[$];
    int          tests = 0;
    int          fails = 0;
    int          vcount = 0;
    logic [31:0] exp_sent = 0;
    logic [31:0] base;
    bit          rand_ready = 0;
    bit          acc_last = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Packet-level model: header then min(len,4) payload flits, last flag on the final one.
    task automatic push_model();
        int unsigned n;
        n = (pkt_len_i > 4) ? 4 : int'(pkt_len_i);
        q.push_back('{data: {pkt_hdr_data_i, pkt_cid_i, 4'(n), pkt_cord_i}, last: (n == 0)});
        for (int i = 0; i < int'(n); i++)
            q.push_back('{data: pkt_data_i[i*32 +: 32], last: (i == int'(n) - 1)});
    endtask

    task automatic step();
        flit_t e;
        ready_and_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        check("v_o_vs_model", 32'(v_o), 32'(q.size() != 0));
        check("packets_sent", packets_sent_o, exp_sent);
        if (prev_stall) check("hold_data", data_o, prev_data);
        if (v_o) vcount++;
        acc_last = pkt_v_i && pkt_ready_o;
        if (v_o && ready_and_i) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                check("flit_data", data_o, e.data);
                check("ready_on_last", 32'(pkt_ready_o), 32'(e.last));
                if (e.last) exp_sent++;
            end
        end else begin
            check("ready_idle", 32'(pkt_ready_o), 32'(!v_o));
        end
        if (acc_last) push_model();
        prev_stall = v_o && !ready_and_i;
        prev_data  = data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [1:0] id, input logic [3:0] l,
                            input logic [17:0] hd, input logic [127:0] d, input bit hold);
        int n;
        pkt_cord_i     = c;
        pkt_cid_i      = id;
        pkt_len_i      = l;
        pkt_hdr_data_i = hd;
        pkt_data_i     = d;
        pkt_v_i        = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_last && n < 200);
        check("accept_timeout", 32'(acc_last), 32'd1);
        if (!hold) pkt_v_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        step();
    endtask

    function automatic logic [127:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        reset_i        = 1'b1;
        pkt_v_i        = 1'b0;
        pkt_cord_i     = '0;
        pkt_cid_i      = '0;
        pkt_len_i      = '0;
        pkt_hdr_data_i = '0;
        pkt_data_i     = '0;
        ready_and_i    = 1'b0;
        #12;
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_packets_sent", packets_sent_o, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        step();

        // single packet, ready tied high
        base = exp_sent;
        send_pkt(8'd7, 2'd2, 4'd3, 18'd0, {32'h0, 32'hA2, 32'hA1, 32'hA0}, 0);
        drain();
        check("single_sent", packets_sent_o, base + 32'd1);

        // header-only packet
        base = exp_sent;
        send_pkt(8'h3C, 2'd1, 4'd0, 18'h2_5A5A, rand_data(), 0);
        drain();
        check("hdr_only_sent", packets_sent_o, base + 32'd1);

        // back-to-back, pkt_v_i held high
        base   = exp_sent;
        vcount = 0;
        for (int i = 0; i < 5; i++)
            send_pkt(8'(i + 1), 2'(i), 4'd2, 18'(i * 3), rand_data(), 1);
        pkt_v_i = 1'b0;
        drain();
        check("b2b_valid_cycles", 32'(vcount), 32'd15);
        check("b2b_sent", packets_sent_o, base + 32'd5);

        // illegal length is clamped to 4 payload flits
        base = exp_sent;
        send_pkt(8'h11, 2'd3, 4'd9, 18'h1_2345, rand_data(), 0);
        drain();
        check("clamp_sent", packets_sent_o, base + 32'd1);

        // random lengths under 50% backpressure
        rand_ready = 1;
        base       = exp_sent;
        for (int p = 0; p < 100; p++) begin
            send_pkt(8'($urandom()), 2'($urandom()), 4'($urandom_range(0, 4)),
                     18'($urandom()), rand_data(), 0);
            if ($urandom_range(0, 1) == 1) step();
        end
        drain();
        check("random_sent", packets_sent_o, base + 32'd100);
        rand_ready = 0;

        // reset in the middle of a body, after two payload flits
        pkt_cord_i     = 8'h55;
        pkt_cid_i      = 2'd1;
        pkt_len_i      = 4'd4;
        pkt_hdr_data_i = 18'h0_00FF;
        pkt_data_i     = rand_data();
        pkt_v_i        = 1'b1;
        step();
        pkt_v_i = 1'b0;
        step();
        step();
        step();
        reset_i = 1'b1;
        #1;
        check("midrst_v_o", 32'(v_o), 32'd0);
        check("midrst_packets_sent", packets_sent_o, 32'd0);
        check("midrst_data_o", data_o, 32'd0);
        check("midrst_pkt_ready", 32'(pkt_ready_o), 32'd0);
        q.delete();
        exp_sent   = 0;
        prev_stall = 0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        step();
        send_pkt(8'h21, 2'd0, 4'd2, 18'h0_0042, {64'h0, 32'hBEEF_0001, 32'hBEEF_0000}, 0);
        drain();
        check("post_rst_sent", packets_sent_o, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
